// File: rtl/machine_dbg_pkg.sv
// Shared types and codes for the run-control / state-dump sequencer.
package machine_dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_REG_FETCH,
        ST_REG_SEND,
        ST_MEM_FETCH,
        ST_MEM_SEND,
        ST_DONE
    } dump_state_e;

    localparam logic [1:0] HALT_NONE  = 2'd0;
    localparam logic [1:0] HALT_EXT   = 2'd1;
    localparam logic [1:0] HALT_STUCK = 2'd2;
    localparam logic [1:0] HALT_LIMIT = 2'd3;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

endpackage

// File: rtl/machine_dump_ctrl_stuck_pc_detector.sv
// Flags a core that keeps presenting the same PC for STUCK_CYCLES consecutive cycles.
module stuck_pc_detector #(
    parameter int unsigned PC_W         = 30,
    parameter int unsigned STUCK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [PC_W-1:0] pc,
    output logic            stuck
);

    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            seen_q, seen_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            same;

    // seen_q keeps the very first enabled cycle from comparing against the reset PC.
    always_comb begin
        same      = seen_q && (pc == prev_pc_q);
        prev_pc_d = prev_pc_q;
        seen_d    = seen_q;
        cnt_d     = cnt_q;
        if (enable) begin
            prev_pc_d = pc;
            seen_d    = 1'b1;
            if (!same) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        stuck = (STUCK_CYCLES != 0) && enable && same &&
                (cnt_q + 32'd1 == 32'(STUCK_CYCLES));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc_q <= '0;
            seen_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            prev_pc_q <= prev_pc_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/machine_dump_ctrl.sv
// Run-control sequencer: halts the core, then streams register file and a memory window
// out as {kind,index,data} records over a valid/ready port.
module machine_dump_ctrl
    import machine_dbg_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PC_W         = 30,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MEM_AW       = 30,
    parameter int unsigned MEM_BASE     = 16384,
    parameter int unsigned MEM_WORDS    = 5,
    parameter int unsigned MAX_CYCLES   = 30,
    parameter int unsigned STUCK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_req,
    input  logic [PC_W-1:0]   pc,
    output logic              cpu_stall,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_kind,
    output logic [MEM_AW-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic [1:0]        halt_cause,
    output logic [31:0]       cycle_count,
    output logic              done
);

    localparam logic [MEM_AW-1:0] LAST_REG = MEM_AW'(NUM_REGS - 1);
    localparam logic [MEM_AW-1:0] LAST_MEM = (MEM_WORDS == 0) ? '0 : MEM_AW'(MEM_WORDS - 1);
    localparam logic [MEM_AW-1:0] BASE     = MEM_AW'(MEM_BASE);

    dump_state_e       state_q, state_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic              kind_q, kind_d;
    logic [MEM_AW-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        cause_q, cause_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              done_q, done_d;
    logic              stuck;
    logic              limit_hit;

    stuck_pc_detector #(
        .PC_W         (PC_W),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_stuck (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_RUN),
        .pc     (pc),
        .stuck  (stuck)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        valid_d       = valid_q;
        kind_d        = kind_q;
        index_d       = index_q;
        data_d        = data_q;
        cause_d       = cause_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        limit_hit     = (MAX_CYCLES != 0) &&
                        ({1'b0, cycle_count_q} + 33'd1 == 33'(MAX_CYCLES));

        case (state_q)
            ST_RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                if (halt_req || stuck || limit_hit) begin
                    state_d = ST_REG_FETCH;
                    idx_d   = '0;
                    cause_d = halt_req ? HALT_EXT : (stuck ? HALT_STUCK : HALT_LIMIT);
                end
            end
            ST_REG_FETCH: begin
                data_d  = rf_rdata;
                kind_d  = KIND_REG;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = ST_REG_SEND;
            end
            ST_REG_SEND: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_REG) begin
                        idx_d = '0;
                        if (MEM_WORDS == 0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_MEM_FETCH;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REG_FETCH;
                    end
                end
            end
            ST_MEM_FETCH: begin
                data_d  = mem_rdata;
                kind_d  = KIND_MEM;
                index_d = BASE + idx_q;
                valid_d = 1'b1;
                state_d = ST_MEM_SEND;
            end
            ST_MEM_SEND: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_MEM) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_MEM_FETCH;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        stall_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            idx_q         <= '0;
            stall_q       <= 1'b0;
            valid_q       <= 1'b0;
            kind_q        <= 1'b0;
            index_q       <= '0;
            data_q        <= '0;
            cause_q       <= HALT_NONE;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            stall_q       <= stall_d;
            valid_q       <= valid_d;
            kind_q        <= kind_d;
            index_q       <= index_d;
            data_q        <= data_d;
            cause_q       <= cause_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
        end
    end

    assign rf_raddr    = (state_q == ST_REG_FETCH) ? idx_q[REG_AW-1:0] : '0;
    assign mem_raddr   = (state_q == ST_MEM_FETCH) ? (BASE + idx_q) : '0;
    assign cpu_stall   = stall_q;
    assign dump_valid  = valid_q;
    assign dump_kind   = kind_q;
    assign dump_index  = index_q;
    assign dump_data   = data_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_count_q;
    assign done        = done_q;

endmodule
